// File: rtl/soc_clk_gate_ctrl_if.sv
// soc_clk_gate_ctrl_if: per-channel activity, wake handshake and gate-enable bundle
interface soc_clk_gate_ctrl_if #(parameter int CH_NUM = 4);
  logic [CH_NUM-1:0] ch_busy, ch_wake_req, ch_wake_ack, gate_en, ch_gated;
  modport master(output ch_busy, ch_wake_req, input ch_wake_ack, gate_en, ch_gated);
  modport slave(input ch_busy, ch_wake_req, output ch_wake_ack, gate_en, ch_gated);
endinterface

// File: rtl/soc_clk_gate_ctrl.sv
// soc_clk_gate_ctrl: idle-timeout clock gating per channel with wake handshake; SOC_CLK_GATE_STAT_EN enables gated-cycle counters
module soc_clk_gate_ctrl #(
  parameter int CH_NUM = 4,
  parameter int IDLE_W = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [IDLE_W-1:0]    idle_thresh,
  input  logic                 force_on,
  input  logic                 stat_clr,
  output logic [CH_NUM*16-1:0] gated_cyc_cnt,
  soc_clk_gate_ctrl_if.slave   cg
);
  typedef enum logic [1:0] {RUN, OFF, WAKE} st_t;
  localparam int WW = WAKE_LAT > 1 ? $clog2(WAKE_LAT) : 1;
  logic [CH_NUM-1:0] gate_en_r, ack_v, gated_v;
  assign cg.gate_en = gate_en_r | {CH_NUM{force_on}};
  assign cg.ch_wake_ack = ack_v;
  assign cg.ch_gated = gated_v;
  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    st_t st, st_n;
    logic [IDLE_W-1:0] icnt, icnt_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic act, hold, hit;
    assign act = cg.ch_busy[i] | cg.ch_wake_req[i];
    assign hold = idle_thresh == '0 || force_on;
    assign hit = !act && !hold && ({1'b0, icnt} + 1'b1 >= {1'b0, idle_thresh});
    // next state and counters; icnt is held at zero outside RUN so each wake starts a fresh idle count
    always_comb begin
      st_n = st == RUN ? (hit ? OFF : RUN) : st == OFF ? (act ? WAKE : OFF) : (wcnt == WW'(WAKE_LAT - 1) ? RUN : WAKE);
      icnt_n = (st != RUN || act || hold) ? '0 : (&icnt ? icnt : icnt + 1'b1);
      wcnt_n = st == WAKE ? wcnt + 1'b1 : '0;
    end
    // state and counter registers; reset leaves the clock running
    always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) begin
        st <= RUN;
        icnt <= '0;
        wcnt <= '0;
      end else begin
        st <= st_n;
        icnt <= icnt_n;
        wcnt <= wcnt_n;
      end
    assign gate_en_r[i] = st != OFF;
    assign ack_v[i] = st == RUN;
    assign gated_v[i] = st == OFF;
`ifdef SOC_CLK_GATE_STAT_EN
    logic [15:0] gcnt;
    // saturating count of edges spent gated without override; clear wins
    always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) gcnt <= '0;
      else if (stat_clr) gcnt <= '0;
      else if (st == OFF && !force_on && !(&gcnt)) gcnt <= gcnt + 1'b1;
    assign gated_cyc_cnt[16*i +: 16] = gcnt;
`else
    assign gated_cyc_cnt[16*i +: 16] = '0;
`endif
  end
`ifndef SOC_CLK_GATE_STAT_EN
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
`endif
endmodule

// File: tb/tb_soc_clk_gate_ctrl.sv
// tb_soc_clk_gate_ctrl: directed and randomized checks against a behavioural gating model
module tb_soc_clk_gate_ctrl;
  localparam int CH = 4, IW = 8, WL = 2;
  logic clk = 0, rst_b = 0, fon = 0, sclr = 0;
  logic [IW-1:0] thr = 4;
  logic [CH*16-1:0] gcc;
  int checks = 0, failures = 0;
  int idle_run [CH];
  int wake_left [CH];
  int gcyc [CH];
  bit off [CH];
  soc_clk_gate_ctrl_if #(.CH_NUM(CH)) ifc();
  soc_clk_gate_ctrl #(.CH_NUM(CH), .IDLE_W(IW), .WAKE_LAT(WL)) dut (
    .clk(clk), .rst_b(rst_b), .idle_thresh(thr), .force_on(fon),
    .stat_clr(sclr), .gated_cyc_cnt(gcc), .cg(ifc.slave)
  );
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    ifc.ch_busy = '0;
    ifc.ch_wake_req = '0;
    rst_b = 0;
    #1;
    rst_b = 1;
  endtask

  task automatic wait_all_off();
    for (int n = 0; n < 60 && ifc.ch_gated != 4'hF; n++) tick();
    check("wait_all_off", ifc.ch_gated, 4'hF);
  endtask

  // behavioural model: a channel is off, counting down its wake latency, or running and counting idle samples
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < CH; i++) begin
        idle_run[i] <= 0;
        off[i] <= 0;
        wake_left[i] <= 0;
        gcyc[i] <= 0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (sclr) gcyc[i] <= 0;
        else if (off[i] && !fon && gcyc[i] < 65535) gcyc[i] <= gcyc[i] + 1;
        if (off[i]) begin
          idle_run[i] <= 0;
          if (ifc.ch_busy[i] | ifc.ch_wake_req[i]) begin
            off[i] <= 0;
            wake_left[i] <= WL;
          end
        end else if (wake_left[i] > 0) wake_left[i] <= wake_left[i] - 1;
        else if (ifc.ch_busy[i] || ifc.ch_wake_req[i] || thr == 0 || fon) idle_run[i] <= 0;
        else begin
          idle_run[i] <= idle_run[i] + 1;
          if (idle_run[i] + 1 >= int'(thr)) off[i] <= 1;
        end
      end
    end
  end

  // compare every cycle outside reset
  always @(negedge clk) if (rst_b) begin
    logic [CH-1:0] eg, ea, eo;
    logic [CH*16-1:0] ec;
    for (int i = 0; i < CH; i++) begin
      eg[i] = !off[i] | fon;
      ea[i] = !off[i] && wake_left[i] == 0;
      eo[i] = off[i];
`ifdef SOC_CLK_GATE_STAT_EN
      ec[16*i +: 16] = gcyc[i][15:0];
`else
      ec[16*i +: 16] = '0;
`endif
    end
    check("model_gate_en", ifc.gate_en, eg);
    check("model_ack", ifc.ch_wake_ack, ea);
    check("model_gated", ifc.ch_gated, eo);
    check("model_cnt", gcc, ec);
  end

  initial begin
    ifc.ch_busy = '0;
    ifc.ch_wake_req = '0;
    #3;
    check("rst_gate_en", ifc.gate_en, 4'hF);
    check("rst_ack", ifc.ch_wake_ack, 4'hF);
    check("rst_gated", ifc.ch_gated, 4'h0);
    check("rst_cnt", gcc, 64'h0);
    @(posedge clk);
    #2;
    rst_b = 1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check("idle_pre_gate", ifc.gate_en, 4'hF);
    end
    tick();
    check("idle_gate_en", ifc.gate_en, 4'h0);
    check("idle_gated", ifc.ch_gated, 4'hF);
    check("idle_ack", ifc.ch_wake_ack, 4'h0);

    do_reset();
    tick();
    tick();
    ifc.ch_busy[1] = 1;
    tick();
    ifc.ch_busy[1] = 0;
    tick();
    check("cancel_e4", ifc.gate_en, 4'b0010);
    tick();
    tick();
    check("cancel_e6", ifc.gate_en, 4'b0010);
    tick();
    check("cancel_e7", ifc.gate_en, 4'b0000);

    ifc.ch_wake_req[2] = 1;
    tick();
    check("wake_gate_k", ifc.gate_en, 4'b0100);
    check("wake_ack_k", ifc.ch_wake_ack, 4'b0000);
    tick();
    check("wake_ack_k1", ifc.ch_wake_ack, 4'b0000);
    tick();
    check("wake_ack_k2", ifc.ch_wake_ack, 4'b0100);
    repeat (3) tick();
    check("wake_hold_ack", ifc.ch_wake_ack, 4'b0100);
    check("wake_hold_gated", ifc.ch_gated, 4'b1011);
    ifc.ch_wake_req[2] = 0;

    wait_all_off();
    fon = 1;
    #1;
    check("force_gate_en", ifc.gate_en, 4'hF);
    repeat (10) tick();
    check("force_gated", ifc.ch_gated, 4'hF);
    check("force_ack", ifc.ch_wake_ack, 4'h0);
    fon = 0;
    #1;
    check("force_release", ifc.gate_en, 4'h0);

    do_reset();
    thr = 0;
    repeat (1000) tick();
    check("thr0_gate_en", ifc.gate_en, 4'hF);
    check("thr0_gated", ifc.ch_gated, 4'h0);
    thr = 4;
    wait_all_off();
    ifc.ch_wake_req[0] = 1;
    tick();
    #1;
    rst_b = 0;
    #1;
    check("arst_gate_en", ifc.gate_en, 4'hF);
    check("arst_ack", ifc.ch_wake_ack, 4'hF);
    ifc.ch_wake_req[0] = 0;
    rst_b = 1;

    do_reset();
    repeat (4) tick();
    repeat (20) tick();
`ifdef SOC_CLK_GATE_STAT_EN
    check("stat_20", gcc[15:0], 16'd20);
`else
    check("stat_tied", gcc, 64'h0);
`endif
    sclr = 1;
    tick();
    sclr = 0;
    check("stat_clr", gcc[15:0], 16'd0);
    tick();
`ifdef SOC_CLK_GATE_STAT_EN
    check("stat_resume", gcc[15:0], 16'd1);
`else
    check("stat_resume_tied", gcc[15:0], 16'd0);
`endif

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      tick();
      if ($urandom_range(0, 63) == 0) thr = IW'($urandom_range(0, 8));
      fon = $urandom_range(0, 31) == 0;
      sclr = $urandom_range(0, 63) == 0;
      for (int i = 0; i < CH; i++) begin
        ifc.ch_busy[i] = $urandom_range(0, 15) == 0;
        if (ifc.ch_wake_req[i] && ifc.ch_wake_ack[i] && $urandom_range(0, 1) == 1) ifc.ch_wake_req[i] = 0;
        else if (!ifc.ch_wake_req[i] && $urandom_range(0, 19) == 0) ifc.ch_wake_req[i] = 1;
      end
      if ($urandom_range(0, 499) == 0) begin
        rst_b = 0;
        #1;
        rst_b = 1;
      end
    end
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
